fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: holds the PC, requests instructions from instruction memory,
//  and loads the IF/ID pipeline register. Takes the PCSel redirect and target from
//  execute/branch control. Applies hazard-unit stalls and flushes the wrong-path
//  instruction on a taken branch or jump.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0013  instruction driven on if_inst when flushed (addi x0,x0,0)
//  TIMEOUT   16             max cycles in WAIT before fetch_err is set (>=2)
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst_n       in   1   reset, synchronous, active-low
//  pc_sel      in   1   1 = redirect PC to pc_target (taken branch/JAL/JALR)
//  pc_target   in   32  redirect target from ALU
//  stall       in   1   1 = hold IF/ID register and PC (hazard unit)
//  imem_req    out  1   request strobe, high for exactly 1 cycle per request
//  imem_addr   out  32  fetch address (= pc while imem_req=1)
//  imem_ack    in   1   response valid, >=1 cycle after imem_req
//  imem_rdata  in   32  instruction, valid with imem_ack
//  if_pc       out  32  PC of instruction in IF/ID
//  if_inst     out  32  instruction in IF/ID
//  if_valid    out  1   IF/ID holds a real (non-bubble) instruction
//  fetch_err   out  1   sticky: ack timeout; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=REQ, drop=0, if_valid=0, if_inst=NOP_INST,
//   if_pc=0, fetch_err=0, timeout counter=0. rst_n is sampled at the edge only, so a
//   reset in mid-operation discards any outstanding request, and a late ack is ignored.
//  imem_req = (state==REQ); imem_addr = pc. Both are combinational from registered state.
//  FSM:
//   REQ : next state is always WAIT. If pc_sel=1 this cycle: pc<=target, drop<=1.
//   WAIT: counter increments each cycle. When it reaches TIMEOUT: fetch_err<=1, go to REQ.
//         On ack with drop=1, or ack together with pc_sel: discard the data, drop<=0, go to REQ.
//         On ack, drop=0, stall=0: if_inst<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go to REQ.
//         On ack, drop=0, stall=1: buf<=rdata, go to HOLD.
//         If pc_sel=1 without ack: pc<=target, drop<=1, stay in WAIT.
//   HOLD: If pc_sel=1: discard buf, pc<=target, go to REQ.
//         If stall=0: IF/ID<=buf and pc, if_valid<=1, pc<=pc+4, go to REQ.
//         Otherwise stay in HOLD.
//  The counter clears on every WAIT exit.
//  Redirect target: pc <= {pc_target[31:1],1'b0}.
//  IF/ID register updates:
//   pc_sel=1 (takes priority over stall): if_valid<=0, if_inst<=NOP_INST, if_pc keeps its value.
//   stall=1 with no pc_sel: if_pc, if_inst and if_valid all hold.
//   stall=0 with no instruction delivered this cycle: if_valid<=0, if_inst<=NOP_INST.
//  PC arithmetic: 32-bit, pc+4 wraps from 32'hFFFF_FFFC to 0 with no flag.
//  fetch_err does not stop fetching.
//  Throughput: with 1-cycle ack and no stall, one instruction every 2 cycles (REQ,WAIT).
// TESTING
//  1 Reset, then 1-cycle ack returning 0x00500093 -> imem_addr=0; if_valid=1,
//    if_inst=0x00500093, if_pc=0; next imem_addr=4.
//  2 pc_sel=1, target=0x101, in WAIT before ack -> ack data dropped, if_valid=0, if_inst=NOP;
//    next request has imem_addr=0x100.
//  3 stall=1 on the cycle of ack -> HOLD; IF/ID unchanged for 3 stall cycles;
//    stall=0 -> buffered inst appears, pc advances by 4.
//  4 pc_sel in HOLD -> buffer discarded, if_valid=0, next request at the target.
//  5 No ack for 16 cycles -> fetch_err=1 and re-request at the same pc; fetch_err stays 1
//    until rst_n=0.
//  6 Start at pc=0xFFFFFFFC with 1-cycle ack -> the following request has imem_addr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/ack handshake and IF/ID register.
// Handles redirects, hazard stalls, wrong-path drop and a sticky ack-timeout flag.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_sel,
    input  logic [31:0] pc_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        fetch_err
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_buf;
    logic          r_drop;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    if_id_t        r_ifid;

    logic [31:0]   w_tgt;
    logic [31:0]   w_pc_inc;
    logic          w_dlv_wait;
    logic          w_dlv_hold;
    logic          w_deliver;
    logic [31:0]   w_new_inst;

    // Redirect targets are forced halfword-aligned
    assign w_tgt      = pc_target & 32'hFFFF_FFFE;
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_dlv_wait = (r_state == S_WAIT) && imem_ack && !r_drop
                        && !pc_sel && !stall;
    assign w_dlv_hold = (r_state == S_HOLD) && !pc_sel && !stall;
    assign w_deliver  = w_dlv_wait || w_dlv_hold;
    assign w_new_inst = (r_state == S_HOLD) ? r_buf : imem_rdata;

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign if_pc      = r_ifid.pc;
    assign if_inst    = r_ifid.inst;
    assign if_valid   = r_ifid.valid;
    assign fetch_err  = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_buf   <= NOP_INST;
            r_drop  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_ifid  <= '{valid: 1'b0, pc: 32'd0, inst: NOP_INST};
        end else begin
            unique case (r_state)
                S_REQ: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                    r_drop  <= pc_sel;
                    if (pc_sel) begin
                        r_pc <= w_tgt;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        r_cnt <= '0;
                        if (r_drop || pc_sel) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                            if (pc_sel) begin
                                r_pc <= w_tgt;
                            end
                        end else if (!stall) begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_REQ;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= S_HOLD;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // Abandon the request; a fresh one goes out next cycle
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                        r_drop  <= 1'b0;
                        r_state <= S_REQ;
                        if (pc_sel) begin
                            r_pc <= w_tgt;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (pc_sel) begin
                            r_pc   <= w_tgt;
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (pc_sel) begin
                        r_pc    <= w_tgt;
                        r_state <= S_REQ;
                    end else if (!stall) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase

            if (pc_sel) begin
                r_ifid.valid <= 1'b0;
                r_ifid.inst  <= NOP_INST;
            end else if (!stall) begin
                if (w_deliver) begin
                    r_ifid.valid <= 1'b1;
                    r_ifid.pc    <= r_pc;
                    r_ifid.inst  <= w_new_inst;
                end else begin
                    r_ifid.valid <= 1'b0;
                    r_ifid.inst  <= NOP_INST;
                end
            end
        end
    end

endmodule
